fb_pingpong_sched: RTL and testbench

Frame-level scheduler that sequences the camera DMA across two framebuffer regions (ping-pong) in the framebuffer SRAM. On each camera start-of-frame it selects a free buffer, then issues a start pulse with that buffer's base and length to the DMA engine. When the DMA reports done it marks the buffer READY for software. Software hands a buffer back through a release strobe driven from a CSR write. The block sits between the CSR block, camera_capture (SOF), simple_dma and irq_ctrl.

---
 rtl/fb_sched_pkg.sv | 22 ++
 rtl/fb_sched_wdog.sv | 45 ++++
 rtl/fb_pingpong_sched.sv | 210 +++++++++++++++++++++
 tb/tb_fb_pingpong_sched.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_sched_pkg.sv
// Shared types and constants for the ping-pong framebuffer scheduler.
//   buf_state_e   : per-buffer ownership state (FREE / FILLING / READY)
//   sched_state_e : scheduler FSM states
//   NUM_BUF       : number of framebuffer regions managed (ping + pong)
package fb_sched_pkg;

  localparam int NUM_BUF = 2;

  typedef enum logic [1:0] {
    BUF_FREE    = 2'd0,
    BUF_FILLING = 2'd1,
    BUF_READY   = 2'd2
  } buf_state_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_ARM      = 2'd2,
    ST_FILL     = 2'd3
  } sched_state_e;

endpackage

// File: rtl/fb_sched_wdog.sv
// Fill watchdog for the framebuffer scheduler.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : zero the counter (takes priority over en)
//   en       : count one cycle
//   limit    : expiry limit in counted cycles; 0 disables expiry
//   expire   : high in the en cycle that completes 'limit' counted cycles
module fb_sched_wdog #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         expire
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q holds the number of cycles already completed, so the cycle that
  // finishes the limit is the one where count_q == limit - 1.
  assign expire = en && (limit != '0) && (count_q == (limit - ONE));

endmodule

// File: rtl/fb_pingpong_sched.sv
// Ping-pong framebuffer scheduler.
// Picks a FREE buffer on each camera SOF, pulses dma_start with that buffer's
// base/length, marks the buffer READY when the DMA signals done (rising edge),
// and returns buffers to FREE on software release. A watchdog aborts fills
// that never complete.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   enable                   : scheduler enable
//   cfg_base0/1, cfg_len     : buffer bases and frame length (bytes)
//   cfg_timeout              : fill watchdog limit in cycles, 0 = off
//   cam_sof                  : start-of-frame pulse
//   dma_done                 : DMA done level
//   rel_valid, rel_idx       : software release strobe and buffer index
//   dma_start/base/len       : DMA launch pulse and parameters
//   frame_ready, ready_idx   : fill-complete pulse and buffer index (held)
//   buf_state                : {buf1, buf0} ownership states
//   drop_count, timeout_count: saturating event counters
//   rel_err                  : release of a non-READY buffer
//   busy                     : FSM not in IDLE
module fb_pingpong_sched
  import fb_sched_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int TIMEOUT_W = 20,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [ADDR_W-1:0]    cfg_base0,
  input  logic [ADDR_W-1:0]    cfg_base1,
  input  logic [ADDR_W-1:0]    cfg_len,
  input  logic [TIMEOUT_W-1:0] cfg_timeout,
  input  logic                 cam_sof,
  input  logic                 dma_done,
  input  logic                 rel_valid,
  input  logic                 rel_idx,
  output logic                 dma_start,
  output logic [ADDR_W-1:0]    dma_base,
  output logic [ADDR_W-1:0]    dma_len,
  output logic                 frame_ready,
  output logic                 ready_idx,
  output logic [3:0]           buf_state,
  output logic [CNT_W-1:0]     drop_count,
  output logic [CNT_W-1:0]     timeout_count,
  output logic                 rel_err,
  output logic                 busy
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  sched_state_e      state_q, state_d;
  buf_state_e        buf_q [NUM_BUF];
  buf_state_e        buf_d [NUM_BUF];
  logic              next_idx_q, next_idx_d;
  logic              fill_idx_q, fill_idx_d;
  logic              done_prev_q;
  logic              dma_start_q, dma_start_d;
  logic [ADDR_W-1:0] dma_base_q, dma_base_d;
  logic [ADDR_W-1:0] dma_len_q, dma_len_d;
  logic              frame_ready_q, frame_ready_d;
  logic              ready_idx_q, ready_idx_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic [CNT_W-1:0]  tmo_q, tmo_d;
  logic              rel_err_q, rel_err_d;

  logic done_edge;
  logic other_idx;
  logic sel_ok;
  logic sel_idx;
  logic wd_clr;
  logic wd_en;
  logic wd_expire;

  assign done_edge = dma_done & ~done_prev_q;

  // Prefer the alternating buffer; fall back to the other one if it is free.
  assign other_idx = ~next_idx_q;
  assign sel_ok    = (buf_q[next_idx_q] == BUF_FREE) || (buf_q[other_idx] == BUF_FREE);
  assign sel_idx   = (buf_q[next_idx_q] == BUF_FREE) ? next_idx_q : other_idx;

  assign wd_clr = (state_q == ST_ARM);
  assign wd_en  = (state_q == ST_FILL);

  fb_sched_wdog #(.W(TIMEOUT_W)) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (wd_clr),
    .en     (wd_en),
    .limit  (cfg_timeout),
    .expire (wd_expire)
  );

  always_comb begin
    state_d       = state_q;
    buf_d         = buf_q;
    next_idx_d    = next_idx_q;
    fill_idx_d    = fill_idx_q;
    dma_start_d   = 1'b0;
    dma_base_d    = dma_base_q;
    dma_len_d     = dma_len_q;
    frame_ready_d = 1'b0;
    ready_idx_d   = ready_idx_q;
    drop_d        = drop_q;
    tmo_d         = tmo_q;
    rel_err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_WAIT_SOF;
      end
      ST_WAIT_SOF: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (cam_sof) begin
          if (sel_ok) begin
            buf_d[sel_idx] = BUF_FILLING;
            fill_idx_d     = sel_idx;
            dma_base_d     = sel_idx ? cfg_base1 : cfg_base0;
            dma_len_d      = cfg_len;
            dma_start_d    = 1'b1;
            state_d        = ST_ARM;
          end else if (drop_q != '1) begin
            drop_d = drop_q + CNT_ONE;
          end
        end
      end
      ST_ARM: begin
        state_d = ST_FILL;
      end
      ST_FILL: begin
        // A done edge in the same cycle as watchdog expiry counts as done.
        if (done_edge) begin
          buf_d[fill_idx_q] = BUF_READY;
          frame_ready_d     = 1'b1;
          ready_idx_d       = fill_idx_q;
          next_idx_d        = ~fill_idx_q;
          state_d           = enable ? ST_WAIT_SOF : ST_IDLE;
        end else if (wd_expire) begin
          buf_d[fill_idx_q] = BUF_FREE;
          if (tmo_q != '1) tmo_d = tmo_q + CNT_ONE;
          state_d = enable ? ST_WAIT_SOF : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Release checks the pre-update state; it can never collide with the
    // FSM's buffer update because those touch FREE/FILLING buffers only.
    if (rel_valid) begin
      if (buf_q[rel_idx] == BUF_READY) begin
        buf_d[rel_idx] = BUF_FREE;
      end else begin
        rel_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      next_idx_q    <= 1'b0;
      fill_idx_q    <= 1'b0;
      done_prev_q   <= 1'b0;
      dma_start_q   <= 1'b0;
      dma_base_q    <= '0;
      dma_len_q     <= '0;
      frame_ready_q <= 1'b0;
      ready_idx_q   <= 1'b0;
      drop_q        <= '0;
      tmo_q         <= '0;
      rel_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      next_idx_q    <= next_idx_d;
      fill_idx_q    <= fill_idx_d;
      done_prev_q   <= dma_done;
      dma_start_q   <= dma_start_d;
      dma_base_q    <= dma_base_d;
      dma_len_q     <= dma_len_d;
      frame_ready_q <= frame_ready_d;
      ready_idx_q   <= ready_idx_d;
      drop_q        <= drop_d;
      tmo_q         <= tmo_d;
      rel_err_q     <= rel_err_d;
    end
  end

  for (genvar gi = 0; gi < NUM_BUF; gi++) begin : g_buf
    always_ff @(posedge clk) begin
      if (rst) begin
        buf_q[gi] <= BUF_FREE;
      end else begin
        buf_q[gi] <= buf_d[gi];
      end
    end
    assign buf_state[2*gi +: 2] = buf_q[gi];
  end

  assign dma_start     = dma_start_q;
  assign dma_base      = dma_base_q;
  assign dma_len       = dma_len_q;
  assign frame_ready   = frame_ready_q;
  assign ready_idx     = ready_idx_q;
  assign drop_count    = drop_q;
  assign timeout_count = tmo_q;
  assign rel_err       = rel_err_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fb_pingpong_sched.sv
// Bench for fb_pingpong_sched: directed walk through the main scenarios
// followed by randomized traffic, all checked every cycle against a
// frame-level reference model.
module tb_fb_pingpong_sched;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        en;
  logic [15:0] base0, base1, len;
  logic [19:0] tmo;
  logic        sof, done, relv, reli;

  logic        dma_start;
  logic [15:0] dma_base, dma_len;
  logic        frame_ready, ready_idx;
  logic [3:0]  buf_state;
  logic [15:0] drop_count, timeout_count;
  logic        rel_err, busy;

  fb_pingpong_sched dut (
    .clk(clk), .rst(rst_i), .enable(en),
    .cfg_base0(base0), .cfg_base1(base1), .cfg_len(len), .cfg_timeout(tmo),
    .cam_sof(sof), .dma_done(done), .rel_valid(relv), .rel_idx(reli),
    .dma_start(dma_start), .dma_base(dma_base), .dma_len(dma_len),
    .frame_ready(frame_ready), .ready_idx(ready_idx), .buf_state(buf_state),
    .drop_count(drop_count), .timeout_count(timeout_count),
    .rel_err(rel_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model. Scheduler phase: 0 off, 1 waiting for a frame,
  // 2 launching, 3 frame in flight. Buffers: 0 free, 1 filling, 2 ready.
  int m_phase, m_next, m_fill, m_age, m_done_prev;
  int m_buf [2];
  int m_start, m_base, m_len, m_fr, m_ridx, m_drop, m_tmo, m_relerr;

  task automatic model_reset();
    m_phase = 0; m_next = 0; m_fill = 0; m_age = 0; m_done_prev = 0;
    m_buf[0] = 0; m_buf[1] = 0;
    m_start = 0; m_base = 0; m_len = 0; m_fr = 0; m_ridx = 0;
    m_drop = 0; m_tmo = 0; m_relerr = 0;
  endtask

  task automatic model_step();
    int pre [2];
    int pick;
    bit edge_seen;
    if (rst_i) begin
      model_reset();
      return;
    end
    pre[0] = m_buf[0]; pre[1] = m_buf[1];
    m_start = 0; m_fr = 0; m_relerr = 0;
    edge_seen = (done && m_done_prev == 0);
    m_done_prev = done ? 1 : 0;
    case (m_phase)
      0: if (en) m_phase = 1;
      1: begin
        if (!en) m_phase = 0;
        else if (sof) begin
          if (pre[m_next] == 0) pick = m_next;
          else if (pre[1 - m_next] == 0) pick = 1 - m_next;
          else pick = -1;
          if (pick >= 0) begin
            m_buf[pick] = 1; m_fill = pick;
            m_base = (pick == 1) ? int'(base1) : int'(base0);
            m_len = int'(len); m_start = 1; m_phase = 2;
          end else if (m_drop < 65535) begin
            m_drop++;
          end
        end
      end
      2: begin m_phase = 3; m_age = 0; end
      default: begin
        m_age++;
        if (edge_seen) begin
          m_buf[m_fill] = 2; m_fr = 1; m_ridx = m_fill; m_next = 1 - m_fill;
          m_phase = en ? 1 : 0;
        end else if (tmo != 0 && m_age == int'(tmo)) begin
          m_buf[m_fill] = 0;
          if (m_tmo < 65535) m_tmo++;
          m_phase = en ? 1 : 0;
        end
      end
    endcase
    if (relv) begin
      if (pre[reli] == 2) m_buf[reli] = 0;
      else m_relerr = 1;
    end
  endtask

  task automatic compare_all();
    chk("dma_start", dma_start, m_start);
    chk("dma_base", dma_base, m_base);
    chk("dma_len", dma_len, m_len);
    chk("frame_ready", frame_ready, m_fr);
    chk("ready_idx", ready_idx, m_ridx);
    chk("buf_state", buf_state, m_buf[1] * 4 + m_buf[0]);
    chk("drop_count", drop_count, m_drop);
    chk("timeout_count", timeout_count, m_tmo);
    chk("rel_err", rel_err, m_relerr);
    chk("busy", busy, (m_phase != 0) ? 1 : 0);
  endtask

  // One clock: model and DUT see the same inputs, outputs checked 1ns after
  // the edge, then the one-cycle strobes are dropped.
  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    compare_all();
    if (m_fr != 0)
      $display("[TB] cyc %0d frame_ready idx=%0d buf_state=0x%0h", cyc, m_ridx, buf_state);
    sof = 1'b0;
    relv = 1'b0;
  endtask

  initial begin
    model_reset();
    rst_i = 1'b1; en = 1'b0; sof = 1'b0; done = 1'b0; relv = 1'b0; reli = 1'b0;
    base0 = 16'h0000; base1 = 16'h4000; len = 16'h4000; tmo = '0;

    // Reset state
    tick(); tick();
    rst_i = 1'b0;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_buf_state", buf_state, 0);
    $display("[TB] reset done");

    // First frame into buffer 0
    en = 1'b1; tick();
    sof = 1'b1; tick();
    chk("t1_start", dma_start, 1);
    chk("t1_base", dma_base, 16'h0000);
    chk("t1_len", dma_len, 16'h4000);
    chk("t1_buf_state", buf_state, 4'b0001);
    tick();
    chk("t1_start_single", dma_start, 0);
    done = 1'b1; tick();
    chk("t2_frame_ready", frame_ready, 1);
    chk("t2_ready_idx", ready_idx, 0);
    chk("t2_buf_state", buf_state, 4'b0010);
    done = 1'b0; tick();
    $display("[TB] frame into buffer 0 complete");

    // Second frame alternates to buffer 1
    sof = 1'b1; tick();
    chk("t2_base1", dma_base, 16'h4000);
    chk("t2_buf_state_b", buf_state, 4'b0110);
    tick();
    done = 1'b1; tick();
    done = 1'b0; tick();
    $display("[TB] frame into buffer 1 complete");

    // Both READY: three SOFs dropped, then release buffer 1
    for (int i = 0; i < 3; i++) begin
      sof = 1'b1; tick(); tick();
    end
    chk("t3_drop", drop_count, 3);
    relv = 1'b1; reli = 1'b1; tick();
    chk("t3_rel_state", buf_state, 4'b0010);
    tmo = 20'd100;
    sof = 1'b1; tick();
    chk("t3_refill_base", dma_base, 16'h4000);
    chk("t3_refill_state", buf_state, 4'b0110);
    $display("[TB] drops and release checked");

    // Watchdog: buffer 1 fill never completes
    for (int i = 0; i < 100; i++) tick();
    chk("t4_before_expiry", timeout_count, 0);
    tick();
    chk("t4_timeout", timeout_count, 1);
    chk("t4_buf_free", buf_state, 4'b0010);
    chk("t4_busy", busy, 1);
    done = 1'b1; tick();
    chk("t4_no_frame_ready", frame_ready, 0);
    tick();
    chk("t4_no_frame_ready2", frame_ready, 0);
    done = 1'b0; tmo = '0; tick();
    $display("[TB] watchdog abort checked");

    // Release errors and same-cycle release/SOF
    relv = 1'b1; reli = 1'b0; tick();
    chk("t5_rel_ok", buf_state, 4'b0000);
    relv = 1'b1; reli = 1'b0; tick();
    chk("t5_rel_err", rel_err, 1);
    chk("t5_rel_err_state", buf_state, 4'b0000);
    for (int i = 0; i < 2; i++) begin
      sof = 1'b1; tick(); tick();
      done = 1'b1; tick();
      done = 1'b0; tick();
    end
    chk("t5_both_ready", buf_state, 4'b1010);
    relv = 1'b1; reli = 1'b0; sof = 1'b1; tick();
    chk("t5_drop_same_cycle", drop_count, 4);
    chk("t5_freed", buf_state, 4'b1000);
    chk("t5_no_start", dma_start, 0);
    $display("[TB] release corner cases checked");

    // Disable mid-fill, then reset mid-fill
    sof = 1'b1; tick(); tick();
    en = 1'b0; tick(); tick();
    chk("t6_busy_in_fill", busy, 1);
    done = 1'b1; tick();
    chk("t6_frame_ready", frame_ready, 1);
    chk("t6_busy", busy, 0);
    done = 1'b0; en = 1'b1; tick();
    relv = 1'b1; reli = 1'b0; tick();
    relv = 1'b1; reli = 1'b1; tick();
    sof = 1'b1; tick(); tick(); tick();
    rst_i = 1'b1; tick();
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_buf", buf_state, 0);
    chk("t6_rst_drop", drop_count, 0);
    chk("t6_rst_base", dma_base, 0);
    rst_i = 1'b0; tick();
    $display("[TB] disable and reset mid-fill checked");

    // Randomized traffic
    for (int c = 0; c < 2500; c++) begin
      en    = ($urandom_range(0, 19) != 0);
      sof   = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) done = ~done;
      relv  = ($urandom_range(0, 5) == 0);
      reli  = 1'($urandom_range(0, 1));
      rst_i = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 99) == 0) begin
        tmo   = ($urandom_range(0, 2) == 0) ? 20'd0 : 20'($urandom_range(3, 40));
        base0 = 16'($urandom);
        base1 = 16'($urandom);
        len   = 16'($urandom);
      end
      tick();
    end
    rst_i = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
